inv_mix_col_seq: RTL and testbench
==================================

# inv_mix_col_seq

Sequenced InvMixColumns engine for the AES decryption round path. It accepts a 128-bit state packet over a valid/ready handshake and processes it one 32-bit column per cycle through a single shared `invMixCol32` instance, rather than four parallel copies. It returns the result over a second valid/ready handshake. A per-packet bypass covers the final decryption round, which skips InvMixColumns.

## Interface
- No parameters. The packet width is 128 and the column count is 4; both are fixed by AES.
- `clk` input 1: system clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_packet` and `in_bypass` are valid.
- `in_packet` input 128: input state. Column 0 = [127:96], column 3 = [31:0].
- `in_bypass` input 1: with the packet, 1 = pass the packet through unmodified.
- `in_ready` output 1: the block can accept a packet this cycle.
- `out_valid` output 1: `out_packet` holds a completed result.
- `out_packet` output 128: result register, same column ordering as `in_packet`.
- `out_ready` input 1: the downstream stage takes the result this cycle.
- `busy` output 1: high in COMPUTE.

## Operation
- States:
  - IDLE: empty.
  - COMPUTE: columns in flight, index `col` 0..3.
  - DONE: result held.
- Input handshake: a packet is accepted on a rising edge where `in_valid && in_ready`.
- Output handshake: a result is taken on a rising edge where `out_valid && out_ready`.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from `out_ready`, which is intentional: it gives back-to-back flow.
- `out_valid` = (state==DONE).
- Accept, no bypass: latch `in_packet` into an internal work register, set `col`=0, go to COMPUTE.
- Accept with bypass: `out_packet` <= `in_packet`, go to DONE.
- COMPUTE, each cycle:
  - The shared `invMixCol32` input is muxed from work-register column `col`.
  - Its output is written into `out_packet` column `col`.
  - `col` increments.
  - On `col`==3, go to DONE and clear `col` to 0. `col` never wraps beyond 3.
- COMPUTE ignores `in_valid`, because `in_ready` is 0. `out_ready` has no effect in COMPUTE.
- DONE: `out_packet` and `out_valid` hold stable until taken. When taken:
  - With a simultaneous accept: branch to COMPUTE or DONE per the new packet's `in_bypass`.
  - Otherwise: go to IDLE.
- Columns of `out_packet` not yet written in COMPUTE keep their previous values. Downstream must sample only when `out_valid` is high.
- Reset, asynchronous, including mid-COMPUTE:
  - State = IDLE, `col` = 0.
  - Work register and `out_packet` = 128'h0.
  - `out_valid` = 0, `busy` = 0, `in_ready` = 1 after reset deasserts.
  - An in-flight packet is discarded with no partial output.

## Timing
- Non-bypass latency: accept at edge E; columns written at edges E+1..E+4; `out_valid` high in the cycle after E+4.
- Bypass latency: `out_valid` high in the cycle after the accept edge.
- Throughput with `out_ready` held at 1:
  - Non-bypass: one packet per 5 cycles.
  - Bypass: one packet per cycle.
- `busy` is high for exactly 4 cycles per non-bypass packet.
- `out_packet` changes only on write edges in COMPUTE, on bypass accept, or on reset.

## Structure
- Shared package `aes_pkg`:
  - `word_t` (logic [31:0]) and `block_t` (logic [127:0]).
  - `col_idx_t` (logic [1:0]).
  - Enum `imc_state_t` {IDLE, COMPUTE, DONE}.
  - Constant `NUM_COLS` = 4.
- Sub-module: exactly one instance of the existing combinational `invMixCol32` (ports `word`, `mixed32`).
- Column select/write uses `col` × 32 part-selects, with column 0 at the MSBs.

## Test plan
- Reset, then assert `rst` mid-COMPUTE → `out_valid`=0, `out_packet`=0, `in_ready`=1 after release. The next packet completes correctly.
- Non-bypass, `in_packet` = 8e4da1bc_9fdc589d_01010101_c6c6c6c6 → after 5 cycles `out_valid`=1 and `out_packet` = db135345_f20a225c_01010101_c6c6c6c6. `busy` is high for exactly 4 cycles.
- Bypass, `in_packet` = 00112233_44556677_8899aabb_ccddeeff → `out_valid` the next cycle with the identical value.
- Backpressure: `out_ready`=0 for 10 cycles in DONE → `out_packet` stable and `in_ready`=0. Then `out_ready`=1 → taken, state goes to IDLE.
- Back-to-back: `out_ready`=1 and `in_valid`=1 continuously with alternating bypass/non-bypass packets (second packet d5d5d7d6_4d7ebdf8_01010101_c6c6c6c6 → d4d4d4d5_2d26314c_01010101_c6c6c6c6) → each accepted in the DONE cycle of its predecessor, results in order, no packet lost or duplicated.
- `in_valid` pulsed during COMPUTE → ignored. Only one result is produced, and it matches the first packet.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types and constants for the decryption round path.
package aes_pkg;

    localparam int NUM_COLS = 4;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;
    typedef logic [1:0]   col_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } imc_state_t;

    localparam col_idx_t LAST_COL = col_idx_t'(NUM_COLS - 1);

    // Bit offset of the LSB of column c inside a block; column 0 sits at the MSBs.
    // For a 2-bit index, ~c equals 3 - c, so {~c, 5'd0} is (3 - c) * 32.
    function automatic logic [6:0] col_lsb(input col_idx_t c);
        return {~c, 5'd0};
    endfunction

endpackage

// File: rtl/inv_mix_col_seq_invmixcol32.sv
// Combinational InvMixColumns on one 32-bit column (byte 0 at the MSBs).
module invMixCol32
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] mixed32
);

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] b);
        return xt(xt(xt(b)) ^ b) ^ b;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] b);
        return xt(xt(xt(b) ^ b)) ^ b;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] b);
        return xt(xt(xt(b) ^ b) ^ b);
    endfunction

    logic [7:0] a0, a1, a2, a3;

    // Apply the inverse MixColumns matrix {0e 0b 0d 09} in circulant form.
    always_comb begin
        a0 = word[31:24];
        a1 = word[23:16];
        a2 = word[15:8];
        a3 = word[7:0];
        mixed32[31:24] = mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3);
        mixed32[23:16] = mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3);
        mixed32[15:8]  = mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3);
        mixed32[7:0]   = mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3);
    end

endmodule

// File: rtl/inv_mix_col_seq.sv
// Sequenced InvMixColumns: one column per cycle through a single shared
// invMixCol32, with a per-packet bypass for the final decryption round.
module inv_mix_col_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [127:0] in_packet,
    input  logic         in_bypass,
    output logic         in_ready,
    output logic         out_valid,
    output logic [127:0] out_packet,
    input  logic         out_ready,
    output logic         busy
);

    imc_state_t state, state_nxt;
    col_idx_t   col;
    block_t     work;
    word_t      col_in;
    word_t      col_out;
    logic       accept;

    assign accept = in_valid && in_ready;
    assign col_in = work[col_lsb(col) +: 32];

    invMixCol32 u_imc (
        .word    (col_in),
        .mixed32 (col_out)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; in_ready follows out_ready in DONE
    // so a new packet can enter in the same cycle the old result leaves.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = in_bypass ? DONE : COMPUTE;
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                if (col == LAST_COL) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        state_nxt = in_bypass ? DONE : COMPUTE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Work register, column counter and result register; accepts never
    // coincide with COMPUTE, so the two write sources are exclusive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work       <= '0;
            out_packet <= '0;
            col        <= '0;
        end else begin
            if (accept && !in_bypass) begin
                work <= in_packet;
                col  <= '0;
            end
            if (accept && in_bypass) begin
                out_packet <= in_packet;
            end
            if (state == COMPUTE) begin
                out_packet[col_lsb(col) +: 32] <= col_out;
                col <= (col == LAST_COL) ? '0 : col + col_idx_t'(1);
            end
        end
    end

endmodule

// File: tb/tb_inv_mix_col_seq.sv
// Bench for inv_mix_col_seq: directed steps plus a scoreboard fed on every
// accepted packet and drained on every taken result.
module tb_inv_mix_col_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_packet;
    logic         in_bypass;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_packet;
    logic         out_ready;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int n_out = 0;

    logic [127:0] sb[$];
    logic [127:0] got[$];

    localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] D1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] V3 = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;
    localparam logic [127:0] D3 = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;

    inv_mix_col_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_packet  (in_packet),
        .in_bypass  (in_bypass),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_packet (out_packet),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] imc_word(input logic [31:0] w);
        logic [7:0] a [4];
        logic [7:0] m [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) a[i] = w[31 - 8*i -: 8];
        for (int row = 0; row < 4; row++) begin
            logic [7:0] acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(m[(k - row + 4) % 4], a[k]);
            r[31 - 8*row -: 8] = acc;
        end
        return r;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] p, input logic byp);
        logic [127:0] r;
        if (byp) return p;
        for (int c = 0; c < 4; c++) r[127 - 32*c -: 32] = imc_word(p[127 - 32*c -: 32]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_nout(input int target, input int budget, input string tag);
        int c = 0;
        while (n_out < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, 128'(n_out), 128'(target));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard monitor: sampled on the falling edge, so a handshake seen
    // here completes on the following rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_out++;
                got.push_back(out_packet);
                check("sb_depth", 128'(sb.size()), 128'd1);
                if (sb.size() > 0) check("out_packet", out_packet, sb.pop_front());
            end
            if (in_valid && in_ready) sb.push_back(model(in_packet, in_bypass));
        end
    end

    logic [127:0] pk  [6];
    logic         byp [6];
    logic [127:0] r1;
    logic         acc;
    int           idx;
    int           cyc;
    int           base;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_packet = '0;
        in_bypass = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_packet", out_packet, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", 128'(in_ready), 128'd1);

        // Non-bypass latency, busy window, then backpressure
        @(posedge clk); #1;
        in_valid = 1'b1; in_bypass = 1'b0; in_packet = V1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("nb_busy", 128'(busy), 128'd1);
            check("nb_not_valid", 128'(out_valid), 128'd0);
        end
        @(negedge clk);
        check("nb_valid", 128'(out_valid), 128'd1);
        check("nb_busy_low", 128'(busy), 128'd0);
        check("nb_result", out_packet, D1);
        @(posedge clk); #1;
        in_valid = 1'b1; in_bypass = 1'b0; in_packet = rnd128();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", out_packet, D1);
            check("bp_valid", 128'(out_valid), 128'd1);
            check("bp_in_ready", 128'(in_ready), 128'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_taken_count", 128'(n_out), 128'd1);
        check("bp_idle_valid", 128'(out_valid), 128'd0);
        check("bp_idle_ready", 128'(in_ready), 128'd1);

        // Bypass: result the cycle after accept, unmodified
        @(posedge clk); #1;
        in_valid = 1'b1; in_bypass = 1'b1; in_packet = V2;
        @(posedge clk); #1;
        in_valid = 1'b0; in_bypass = 1'b0;
        @(negedge clk);
        check("byp_valid", 128'(out_valid), 128'd1);
        check("byp_result", out_packet, V2);
        check("byp_busy", 128'(busy), 128'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        check("byp_count", 128'(n_out), 128'd2);

        // in_valid pulsed during COMPUTE is ignored
        out_ready = 1'b1;
        r1 = rnd128();
        @(posedge clk); #1;
        in_valid = 1'b1; in_bypass = 1'b0; in_packet = r1;
        @(posedge clk); #1;
        in_packet = rnd128(); in_bypass = 1'b1;
        @(negedge clk);
        check("cmp_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_bypass = 1'b0;
        wait_nout(3, 12, "cmp_one_result");
        repeat (4) @(posedge clk);
        #1;
        check("cmp_count", 128'(n_out), 128'd3);
        check("cmp_value", got[got.size() - 1], model(r1, 1'b0));
        out_ready = 1'b0;

        // Asynchronous reset in the middle of COMPUTE
        @(posedge clk); #1;
        in_valid = 1'b1; in_bypass = 1'b0; in_packet = V2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 128'(out_valid), 128'd0);
        check("mid_rst_packet", out_packet, 128'd0);
        check("mid_rst_busy", 128'(busy), 128'd0);
        sb.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rel_ready", 128'(in_ready), 128'd1);
        check("mid_rel_packet", out_packet, 128'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_bypass = 1'b0; in_packet = V1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_nout(4, 12, "post_rst_result");
        @(posedge clk); #1;
        check("post_rst_value", got[got.size() - 1], D1);

        // Back-to-back alternating bypass / non-bypass
        pk[0] = V2;       byp[0] = 1'b1;
        pk[1] = V3;       byp[1] = 1'b0;
        pk[2] = rnd128(); byp[2] = 1'b1;
        pk[3] = rnd128(); byp[3] = 1'b0;
        pk[4] = rnd128(); byp[4] = 1'b1;
        pk[5] = V1;       byp[5] = 1'b0;
        got.delete();
        base = n_out;
        idx  = 0;
        cyc  = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_packet = pk[0]; in_bypass = byp[0];
        while (idx < 6 && cyc < 100) begin
            @(negedge clk);
            acc = in_ready;
            if (acc && idx > 0) check("b2b_accept_in_done", 128'(out_valid), 128'd1);
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 6) begin
                    in_packet = pk[idx]; in_bypass = byp[idx];
                end else begin
                    in_valid = 1'b0; in_bypass = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check("b2b_all_accepted", 128'(idx), 128'd6);
        wait_nout(base + 6, 20, "b2b_outputs");
        repeat (3) @(posedge clk);
        #1;
        check("b2b_count", 128'(n_out), 128'(base + 6));
        if (got.size() > 1) check("b2b_second", got[1], D3);
        else check("b2b_got_size", 128'(got.size()), 128'd6);
        check("b2b_sb_empty", 128'(sb.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
